// File: rtl/video_timing_ctrl.sv
// -----------------------------------------------------------------------------
// video_timing_ctrl
//
// Frame scheduler and raster timing generator for the pixel pipeline.
// A start command launches the raster at pixel (0,0) on the next clock. The
// block then runs the latched number of frames, or free-runs when that number
// is 0. A stop command is held off until the current frame's last pixel, so
// downstream consumers only ever see whole frames.
//
// The default parameters give VESA 1600x900@60 reduced blanking with a
// 108 MHz pixel clock.
//
// Optional build macro: VTC_FRAME_CNT_EN
//   When it is defined, the frame_cnt and underrun outputs are added.
//   When it is undefined, those ports do not exist and nothing else changes.
//
// Ports:
//   clk          in   pixel clock
//   rst          in   asynchronous reset, active-low
//   start        in   single-cycle start request (ignored while busy)
//   stop         in   single-cycle stop request, honoured at frame end
//   run_frames   in   [15:0] frames to run, latched at start; 0 = free-run
//   busy         out  high while running or while a stop is pending
//   frame_start  out  pulse coincident with pixel (0,0)
//   frame_done   out  pulse coincident with pixel (HTOTAL-1, VTOTAL-1)
//   h_cnt        out  [10:0] horizontal position
//   v_cnt        out  [10:0] vertical position
//   vga_dv_o     out  active-video flag
//   vga_hs_o     out  horizontal sync (active level HS_POL)
//   vga_vs_o     out  vertical sync (active level VS_POL)
//   frame_cnt    out  [15:0] completed frames since last start (macro only)
//   underrun     out  sticky flag: start seen while busy (macro only)
// -----------------------------------------------------------------------------
module video_timing_ctrl #(
  parameter int unsigned HRES   = 1600,
  parameter int unsigned HFP    = 24,
  parameter int unsigned HSYNC  = 80,
  parameter int unsigned HBP    = 96,
  parameter int unsigned VRES   = 900,
  parameter int unsigned VFP    = 1,
  parameter int unsigned VSYNC  = 3,
  parameter int unsigned VBP    = 96,
  parameter bit          HS_POL = 1'b1,
  parameter bit          VS_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] run_frames,
  output logic        busy,
  output logic        frame_start,
  output logic        frame_done,
  output logic [10:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        vga_dv_o,
  output logic        vga_hs_o,
  output logic        vga_vs_o
`ifdef VTC_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt,
  output logic        underrun
`endif
);

  // ---------------------------------------------------------------------------
  // Derived timing constants
  // ---------------------------------------------------------------------------
  localparam int unsigned HTOTAL = HRES + HFP + HSYNC + HBP;
  localparam int unsigned VTOTAL = VRES + VFP + VSYNC + VBP;

  // The 11-bit counters can only address totals of up to 2048.
  generate
    if ((HTOTAL > 2048) || (VTOTAL > 2048) || (HTOTAL == 0) || (VTOTAL == 0)) begin : g_bad_totals
      $error("video_timing_ctrl: HTOTAL=%0d / VTOTAL=%0d must be in 1..2048", HTOTAL, VTOTAL);
    end
  endgenerate

  localparam logic [10:0] H_LAST = 11'(HTOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(VTOTAL - 1);

  // Decode bounds are 12 bits wide because HRES (or HRES+HFP+HSYNC) may equal
  // 2048 when the porches are zero, and 11 bits cannot hold that value.
  localparam logic [11:0] H_ACT    = 12'(HRES);
  localparam logic [11:0] H_HS_BEG = 12'(HRES + HFP);
  localparam logic [11:0] H_HS_END = 12'(HRES + HFP + HSYNC);
  localparam logic [11:0] V_ACT    = 12'(VRES);
  localparam logic [11:0] V_VS_BEG = 12'(VRES + VFP);
  localparam logic [11:0] V_VS_END = 12'(VRES + VFP + VSYNC);

  localparam logic [15:0] FCNT_MAX = 16'hFFFF;

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [10:0] h_reg, h_next;
  logic [10:0] v_reg, v_next;
  logic [15:0] len_reg, len_next;     // run_frames latched at start
  logic [15:0] fcnt_reg, fcnt_next;   // frames completed since start

  logic        busy_reg, frame_start_reg, frame_done_reg;
  logic        dv_reg, hs_reg, vs_reg;

  logic        run_next;
  logic        last_px;
  logic        limit_hit;
  logic        fs_next, fd_next;
  logic        dv_next, hs_next, vs_next;

  // ---------------------------------------------------------------------------
  // Next-state, counter and decode logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    h_next     = h_reg;
    v_next     = v_reg;
    len_next   = len_reg;
    fcnt_next  = fcnt_reg;

    // The current pixel is the last pixel of a frame. frame_done is high in
    // this cycle, so any end-of-frame decision is made here.
    last_px   = (h_reg == H_LAST) && (v_reg == V_LAST);
    limit_hit = (len_reg != 16'd0) && (fcnt_reg == len_reg);

    unique case (state_reg)
      ST_IDLE: begin
        h_next = 11'd0;
        v_next = 11'd0;
        if (start) begin
          state_next = ST_RUN;
          len_next   = run_frames;
          fcnt_next  = 16'd0;
        end
      end

      ST_RUN, ST_STOP_PEND: begin
        if (h_reg == H_LAST) begin
          h_next = 11'd0;
          v_next = (v_reg == V_LAST) ? 11'd0 : v_reg + 11'd1;
        end else begin
          h_next = h_reg + 11'd1;
        end

        if (last_px) begin
          // A stop that arrives on the last pixel itself ends the frame here,
          // so no extra frame is started.
          if ((state_reg == ST_STOP_PEND) || stop || limit_hit) begin
            state_next = ST_IDLE;
            h_next     = 11'd0;
            v_next     = 11'd0;
          end
        end else if ((state_reg == ST_RUN) && stop) begin
          state_next = ST_STOP_PEND;
        end
      end

      default: begin
        state_next = ST_IDLE;
        h_next     = 11'd0;
        v_next     = 11'd0;
      end
    endcase

    // Decode from the next counter values, so that the registered flags line
    // up with h_cnt/v_cnt in the same cycle.
    run_next = (state_next != ST_IDLE);
    fs_next  = run_next && (h_next == 11'd0) && (v_next == 11'd0);
    fd_next  = run_next && (h_next == H_LAST) && (v_next == V_LAST);

    // The frame counter advances together with the frame_done pulse. It is
    // therefore already up to date on the last pixel, where limit_hit is
    // evaluated. It saturates so that free-run cannot wrap.
    if (fd_next && (fcnt_next != FCNT_MAX)) begin
      fcnt_next = fcnt_next + 16'd1;
    end

    dv_next = run_next
              && ({1'b0, h_next} < H_ACT)
              && ({1'b0, v_next} < V_ACT);
    hs_next = (run_next && ({1'b0, h_next} >= H_HS_BEG) && ({1'b0, h_next} < H_HS_END))
              ? HS_POL : ~HS_POL;
    vs_next = (run_next && ({1'b0, v_next} >= V_VS_BEG) && ({1'b0, v_next} < V_VS_END))
              ? VS_POL : ~VS_POL;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_reg           <= 11'd0;
      v_reg           <= 11'd0;
      len_reg         <= 16'd0;
      fcnt_reg        <= 16'd0;
      busy_reg        <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      dv_reg          <= 1'b0;
      hs_reg          <= ~HS_POL;
      vs_reg          <= ~VS_POL;
    end else begin
      h_reg           <= h_next;
      v_reg           <= v_next;
      len_reg         <= len_next;
      fcnt_reg        <= fcnt_next;
      busy_reg        <= run_next;
      frame_start_reg <= fs_next;
      frame_done_reg  <= fd_next;
      dv_reg          <= dv_next;
      hs_reg          <= hs_next;
      vs_reg          <= vs_next;
    end
  end

  assign busy        = busy_reg;
  assign frame_start = frame_start_reg;
  assign frame_done  = frame_done_reg;
  assign h_cnt       = h_reg;
  assign v_cnt       = v_reg;
  assign vga_dv_o    = dv_reg;
  assign vga_hs_o    = hs_reg;
  assign vga_vs_o    = vs_reg;

`ifdef VTC_FRAME_CNT_EN
  // ---------------------------------------------------------------------------
  // Frame count and underrun observation
  // ---------------------------------------------------------------------------
  logic underrun_reg;

  // The flag is only updated when start is seen. A start while busy sets it.
  // A start that is accepted in IDLE clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun_reg <= 1'b0;
    end else if (start) begin
      underrun_reg <= (state_reg != ST_IDLE);
    end
  end

  assign frame_cnt = fcnt_reg;
  assign underrun  = underrun_reg;
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_video_timing_ctrl
//
// Directed self-checking bench for video_timing_ctrl. It uses small raster
// parameters: HTOTAL=15, VTOTAL=8, so a frame is 120 pixels. Expected values
// come from the pixel index inside the frame: h = p % 15 and v = p / 15.
// -----------------------------------------------------------------------------
module tb_video_timing_ctrl;

  localparam int HT = 15;
  localparam int VT = 8;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] run_frames = 16'd0;
  logic        busy, frame_start, frame_done;
  logic [10:0] h_cnt, v_cnt;
  logic        vga_dv_o, vga_hs_o, vga_vs_o;
`ifdef VTC_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  logic        underrun;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;
  int fd_n, dv_n, fs_n, busy_n;

  always #5 clk = ~clk;

  video_timing_ctrl #(
    .HRES(8), .HFP(2), .HSYNC(3), .HBP(2),
    .VRES(4), .VFP(1), .VSYNC(2), .VBP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .run_frames  (run_frames),
    .busy        (busy),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .vga_dv_o    (vga_dv_o),
    .vga_hs_o    (vga_hs_o),
    .vga_vs_o    (vga_vs_o)
`ifdef VTC_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt),
    .underrun    (underrun)
`endif
  );

  // Packed snapshot {h, v, dv, hs, vs, frame_start, frame_done, busy}.
  function automatic logic [31:0] obs_vec();
    return {4'd0, h_cnt, v_cnt, vga_dv_o, vga_hs_o, vga_vs_o, frame_start, frame_done, busy};
  endfunction

  // Expected snapshot for pixel index p (0..FR-1) of a running frame.
  function automatic logic [31:0] exp_pix(input int p);
    int h;
    int v;
    h = p % HT;
    v = p / HT;
    return {4'd0, 11'(h), 11'(v),
            (h < 8) && (v < 4),
            (h >= 10) && (h <= 12),
            (v == 5) || (v == 6),
            (p == 0),
            (p == FR - 1),
            1'b1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    cmp_cnt++;
    assert (o === e) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // ---- Reset values ----
    repeat (3) step();
    chk("reset_state", obs_vec(), 32'd0);
`ifdef VTC_FRAME_CNT_EN
    chk("reset_fcnt", {15'd0, frame_cnt, underrun}, 32'd0);
`endif
    rst = 1'b1;
    step();
    chk("idle_hold", obs_vec(), 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_in_idle", obs_vec(), 32'd0);

    // ---- One programmed frame with full line/frame decode ----
    run_frames = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    fd_n = 0;
    dv_n = 0;
    for (int i = 0; i < FR; i++) begin
      chk($sformatf("t1_px%0d", i), obs_vec(), exp_pix(i));
      fd_n += int'(frame_done);
      dv_n += int'(vga_dv_o);
      step();
    end
    chk("t1_end_idle", obs_vec(), 32'd0);
    chk("t1_fd_count", fd_n, 32'd1);
    chk("t1_dv_count", dv_n, 32'd32);

    // ---- Free-run; the stop at cycle 50 of frame 2 ends at that frame ----
    run_frames = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    run_frames = 16'd1;  // changed after start: the latched 0 must stay in force
    fd_n = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      chk($sformatf("t2_px%0d", i), obs_vec(), exp_pix(i % FR));
      fd_n += int'(frame_done);
      stop = (i == FR + 50);
      step();
    end
    stop = 1'b0;
    chk("t2_end_idle", obs_vec(), 32'd0);
    chk("t2_fd_count", fd_n, 32'd2);

    // ---- A stop coincident with frame_done ends after frame 1 ----
    run_frames = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < FR; i++) begin
      chk($sformatf("t3_px%0d", i), obs_vec(), exp_pix(i));
      stop = (i == FR - 1);
      step();
    end
    stop = 1'b0;
    chk("t3_idle_no_frame2", obs_vec(), 32'd0);

    // ---- A start in the first IDLE cycle is accepted ----
    run_frames = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_restart", obs_vec(), exp_pix(0));

    // ---- Asynchronous reset in mid-frame at h=5, v=2 ----
    repeat (35) step();
    chk("t4_pre_reset", obs_vec(), exp_pix(35));
    #1 rst = 1'b0;
    #1 chk("t4_async_reset", obs_vec(), 32'd0);
    step();
    chk("t4_reset_held", obs_vec(), 32'd0);
    rst = 1'b1;
    fs_n = 0;
    busy_n = 0;
    repeat (20) begin
      step();
      fs_n += int'(frame_start);
      busy_n += int'(busy);
    end
    chk("t4_no_frame_start", fs_n, 32'd0);
    chk("t4_no_busy", busy_n, 32'd0);
    chk("t4_idle", obs_vec(), 32'd0);

`ifdef VTC_FRAME_CNT_EN
    // ---- Three frames, with a start in mid-frame 2 (underrun) ----
    run_frames = 16'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_fcnt_start", {16'd0, frame_cnt}, 32'd0);
    for (int i = 0; i < 3 * FR; i++) begin
      chk($sformatf("t5_px%0d", i), obs_vec(), exp_pix(i % FR));
      start = (i == FR + 60);
      step();
    end
    start = 1'b0;
    chk("t5_end_idle", obs_vec(), 32'd0);
    chk("t5_fcnt", {16'd0, frame_cnt}, 32'd3);
    chk("t5_underrun", {31'd0, underrun}, 32'd1);
    run_frames = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_clear", {15'd0, frame_cnt, underrun}, 32'd0);
    chk("t5_restart", obs_vec(), exp_pix(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
